// File: rtl/bsg_gateway_io_responder.sv
// Testbench-side MMIO target that answers the chip's uncached I/O commands (putchar, finish, scratch, cycle counter).
// Define GATEWAY_IO_CYCLE_CTR_EN to build the free-running cycle counter readable at cycle_addr_p.
module bsg_gateway_io_responder #(
  parameter int unsigned paddr_width_p   = 40,
  parameter int unsigned data_width_p    = 64,
  parameter int unsigned payload_width_p = 16,
  parameter int unsigned num_core_p      = 1,
  parameter int unsigned resp_latency_p  = 4,
  parameter logic [63:0] putchar_addr_p  = 64'h101000,
  parameter logic [63:0] finish_base_p   = 64'h102000,
  parameter logic [63:0] cycle_addr_p    = 64'h103000,
  parameter logic [63:0] scratch_addr_p  = 64'h104000
) (
  input  logic                       blackparrot_clk,
  input  logic                       blackparrot_reset,
  input  logic [3:0]                 io_cmd_type_i,
  input  logic [paddr_width_p-1:0]   io_cmd_addr_i,
  input  logic [2:0]                 io_cmd_size_i,
  input  logic [payload_width_p-1:0] io_cmd_payload_i,
  input  logic [data_width_p-1:0]    io_cmd_data_i,
  input  logic                       io_cmd_v_i,
  output logic                       io_cmd_ready_o,
  output logic [3:0]                 io_resp_type_o,
  output logic [paddr_width_p-1:0]   io_resp_addr_o,
  output logic [2:0]                 io_resp_size_o,
  output logic [payload_width_p-1:0] io_resp_payload_o,
  output logic [data_width_p-1:0]    io_resp_data_o,
  output logic                       io_resp_v_o,
  input  logic                       io_resp_yumi_i,
  output logic                       putchar_v_o,
  output logic [7:0]                 putchar_o,
  output logic [num_core_p-1:0]      finish_o,
  output logic                       error_o
);

  localparam int unsigned pw_lp  = paddr_width_p;
  localparam int unsigned dw_lp  = data_width_p;
  localparam int unsigned cnt_w_lp = (resp_latency_p < 2) ? 1 : $clog2(resp_latency_p);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e                state_r, state_n;
  logic [cnt_w_lp-1:0]   wait_cnt_r, wait_cnt_n;
  logic                  accept_c;

  logic                       ready_r;
  logic                       resp_v_r;
  logic [3:0]                 resp_type_r;
  logic [pw_lp-1:0]           resp_addr_r;
  logic [2:0]                 resp_size_r;
  logic [payload_width_p-1:0] resp_payload_r;
  logic [dw_lp-1:0]           resp_data_r;
  logic                       putchar_v_r;
  logic [7:0]                 putchar_r;
  logic [num_core_p-1:0]      finish_r;
  logic                       error_r;
  logic [dw_lp-1:0]           scratch_r;
  logic [dw_lp-1:0]           cycle_data_c;

  logic                  is_rd_c, is_wr_c;
  logic                  putchar_hit_c, fin_hit_c, cycle_hit_c, scratch_hit_c;
  logic [pw_lp-1:0]      fin_off_c;
  logic [num_core_p-1:0] fin_set_c;
  logic [dw_lp-1:0]      byte_mask_c;
  logic [dw_lp-1:0]      rd_data_c;
  logic                  cmd_err_c;

`ifdef GATEWAY_IO_CYCLE_CTR_EN
  localparam bit cycle_en_lp = 1'b1;
  logic [63:0] cycle_cnt_r;

  // Free-running cycle counter, wraps naturally
  always_ff @(posedge blackparrot_clk or negedge blackparrot_reset) begin
    if (!blackparrot_reset) cycle_cnt_r <= '0;
    else                    cycle_cnt_r <= cycle_cnt_r + 64'd1;
  end
  assign cycle_data_c = dw_lp'(cycle_cnt_r);
`else
  localparam bit cycle_en_lp = 1'b0;
  assign cycle_data_c = '0;
`endif

  // Address decode, size mask and read data for the command currently on the inputs
  always_comb begin
    is_rd_c       = (io_cmd_type_i == 4'd0);
    is_wr_c       = (io_cmd_type_i == 4'd1);
    byte_mask_c   = (io_cmd_size_i >= 3'd3) ? '1
                  : (dw_lp'(1) << (32'd8 << io_cmd_size_i)) - dw_lp'(1);
    putchar_hit_c = (io_cmd_addr_i == pw_lp'(putchar_addr_p));
    cycle_hit_c   = (io_cmd_addr_i == pw_lp'(cycle_addr_p));
    scratch_hit_c = (io_cmd_addr_i == pw_lp'(scratch_addr_p));
    fin_off_c     = io_cmd_addr_i - pw_lp'(finish_base_p);
    fin_hit_c     = (io_cmd_addr_i >= pw_lp'(finish_base_p))
                 && (fin_off_c < pw_lp'(8 * num_core_p));
    fin_set_c     = '0;
    for (int i = 0; i < int'(num_core_p); i++) begin
      if ((fin_off_c >> 3) == pw_lp'(i)) fin_set_c[i] = 1'b1;
    end
    rd_data_c = '0;
    cmd_err_c = 1'b0;
    if (is_wr_c) begin
      if (!(putchar_hit_c || fin_hit_c || scratch_hit_c)) cmd_err_c = 1'b1;
    end else if (is_rd_c) begin
      if (scratch_hit_c)                    rd_data_c = scratch_r & byte_mask_c;
      else if (cycle_hit_c && cycle_en_lp)  rd_data_c = cycle_data_c & byte_mask_c;
      else                                  cmd_err_c = 1'b1;
    end else begin
      cmd_err_c = 1'b1;
    end
  end

  // Next-state logic: IDLE -> (WAIT) -> RESP -> IDLE
  always_comb begin
    state_n    = state_r;
    wait_cnt_n = wait_cnt_r;
    accept_c   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (io_cmd_v_i && ready_r) begin
          accept_c = 1'b1;
          if (resp_latency_p == 0) begin
            state_n = S_RESP;
          end else begin
            state_n    = S_WAIT;
            wait_cnt_n = cnt_w_lp'(resp_latency_p - 1);
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt_r == '0) state_n = S_RESP;
        else                  wait_cnt_n = wait_cnt_r - cnt_w_lp'(1);
      end
      S_RESP: begin
        if (resp_v_r && io_resp_yumi_i) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge blackparrot_clk or negedge blackparrot_reset) begin
    if (!blackparrot_reset) begin
      state_r    <= S_IDLE;
      wait_cnt_r <= '0;
    end else begin
      state_r    <= state_n;
      wait_cnt_r <= wait_cnt_n;
    end
  end

  // Registered handshake, response capture and side effects
  always_ff @(posedge blackparrot_clk or negedge blackparrot_reset) begin
    if (!blackparrot_reset) begin
      ready_r        <= 1'b0;
      resp_v_r       <= 1'b0;
      resp_type_r    <= '0;
      resp_addr_r    <= '0;
      resp_size_r    <= '0;
      resp_payload_r <= '0;
      resp_data_r    <= '0;
      putchar_v_r    <= 1'b0;
      putchar_r      <= '0;
      finish_r       <= '0;
      error_r        <= 1'b0;
      scratch_r      <= '0;
    end else begin
      ready_r     <= (state_n == S_IDLE);
      putchar_v_r <= 1'b0;
      if (state_r == S_RESP && !resp_v_r)  resp_v_r <= 1'b1;
      else if (resp_v_r && io_resp_yumi_i) resp_v_r <= 1'b0;
      if (accept_c) begin
        resp_type_r    <= io_cmd_type_i;
        resp_addr_r    <= io_cmd_addr_i;
        resp_size_r    <= io_cmd_size_i;
        resp_payload_r <= io_cmd_payload_i;
        resp_data_r    <= rd_data_c;
        if (cmd_err_c) error_r <= 1'b1;
        if (is_wr_c && putchar_hit_c) begin
          putchar_v_r <= 1'b1;
          putchar_r   <= io_cmd_data_i[7:0];
        end
        if (is_wr_c && fin_hit_c) finish_r <= finish_r | fin_set_c;
        if (is_wr_c && scratch_hit_c)
          scratch_r <= (scratch_r & ~byte_mask_c) | (io_cmd_data_i & byte_mask_c);
      end
    end
  end

  assign io_cmd_ready_o    = ready_r;
  assign io_resp_v_o       = resp_v_r;
  assign io_resp_type_o    = resp_type_r;
  assign io_resp_addr_o    = resp_addr_r;
  assign io_resp_size_o    = resp_size_r;
  assign io_resp_payload_o = resp_payload_r;
  assign io_resp_data_o    = resp_data_r;
  assign putchar_v_o       = putchar_v_r;
  assign putchar_o         = putchar_r;
  assign finish_o          = finish_r;
  assign error_o           = error_r;

endmodule
